mmio_gpio_bank: RTL and testbench
=================================

Name: mmio_gpio_bank

Overview:
Parametrised memory-mapped GPIO bank on the CPU data bus, clocked by data_clk.
- Replaces the fixed-width LED/switch/button decode with a 16-word register window.
- Adds input synchronisation, per-button debounce, sticky edge capture with write-1-to-clear, an interrupt request, atomic LED set/clear and a registered 1-cycle read port.

Parameters:
NUM_BTN, 5, number of push-button inputs (1..16)
NUM_SW, 24, number of switch inputs (1..32)
NUM_LED, 24, number of LED outputs (1..32)
DEBOUNCE_CYCLES, 20000, consecutive stable data_clk cycles before a button level is accepted (>=2)
BASE_ADDR, 16'h0040, window base; must be 64-byte aligned

Ports:
data_clk  input  1  bus and logic clock
rst  input  1  reset
addr  input  16  byte address; addr[1:0] ignored
write_data  input  32  write data
wen  input  1  write strobe, sampled on posedge data_clk
ren  input  1  read strobe
read_data  output  32  registered read data
read_valid  output  1  one-cycle pulse qualifying read_data
buttons  input  NUM_BTN  raw asynchronous buttons
switches  input  NUM_SW  raw asynchronous switches
led  output  NUM_LED  LED drive
irq  output  1  level interrupt request

Behaviour:
- Reset rst is asynchronous, active-high; the clock is data_clk. All state is on posedge data_clk.
- Reset values: read_data=0, read_valid=0, led=0, irq=0, all synchronisers, debounce counters, levels, events and enables = 0.
- Select: sel = (addr[15:6]==BASE_ADDR[15:6]). Word index idx = addr[5:2]. Writes when sel is low are ignored.
- Register map (offset, access, content):
  - 0x00 RO: ID 32'h4750_494F.
  - 0x04 RO: synchronised switches, zero-extended.
  - 0x08 RO: debounced button levels.
  - 0x0C R/W1C: sticky rising-edge events, bits [NUM_BTN-1:0].
  - 0x10 RW: irq enable, bits [NUM_BTN-1:0].
  - 0x14 RW: LED register.
  - 0x18 WO: LED set mask (led |= wdata).
  - 0x1C WO: LED clear mask (led &= ~wdata).
  - Other offsets read 0; writes to them are ignored. Bits above the parameter width read 0 and are not stored.
- Synchronisers: 2-flop chain on every button and switch bit. Switch value is visible at 0x04 two cycles after the input changes.
- Debounce, per button:
  - Counter cnt, width $clog2(DEBOUNCE_CYCLES+1).
  - If sync != level: cnt increments. When cnt reaches DEBOUNCE_CYCLES-1, level <= sync and cnt <= 0.
  - If sync == level: cnt <= 0. Any bounce restarts the count.
  - A 0->1 level transition produces a one-cycle rise pulse.
- Events: event[i] <= rise[i] | (event[i] & ~(w1c_write & write_data[i])). If rise and clear hit the same bit in the same cycle, set wins.
- irq is registered: irq <= |(event & irq_en). It deasserts one cycle after the last enabled event is cleared.
- LED:
  - Writes to 0x14/0x18/0x1C take effect on the write edge.
  - Only one write per cycle is possible, so there are no set/clear collisions.
  - led drives the register directly.
- Read:
  - If ren & sel, read_data <= selected value on that edge and read_valid <= 1 for one cycle. Latency is exactly 1 cycle.
  - Otherwise read_valid <= 0 and read_data holds its last value.
  - Reads have no side effects.
  - ren and wen in the same cycle: the read returns the pre-write value.
- Reset mid-debounce discards partial counts. Events pending at reset are lost.

Optional Feature:
MMIO_GPIO_FALL_EDGE_EN
- Defined: falling-edge events are captured in bits [16+NUM_BTN-1:16] of 0x0C, with the same W1C and set-wins rules. The irq enable at 0x10 gains matching bits [16+NUM_BTN-1:16]. NUM_BTN is limited to 16.
- Undefined: those bits read 0, writes to them are ignored, and no falling-edge logic is generated.

Decomposition:
- Package mmio_gpio_pkg holds:
  - offset localparams (OFF_ID, OFF_SW, OFF_BTN, OFF_EVT, OFF_IEN, OFF_LED, OFF_LSET, OFF_LCLR);
  - GPIO_ID constant;
  - the register-index enum typedef.
- Sub-module btn_debounce (synchroniser + counter + level + rise/fall pulses), one instance per button via generate.

Test Plan:
1. Reset, then read 0x40 -> read_valid pulses one cycle after ren; read_data=32'h4750_494F. Read 0x5C -> 0.
2. DEBOUNCE_CYCLES=4; button0 high with a 1-cycle glitch low after 2 cycles, then stable -> level and 0x4C bit0 set only after 4 stable cycles post-glitch.
3. Enable irq bit0 (write 0x50=1), press button0 -> irq=1. Write 0x4C=1 -> irq=0 one cycle later. A rise in the same cycle as the clear -> event stays 1.
4. Write 0x54=0x00F0, then 0x58=0x000F, then 0x5C=0x0030 -> led=0x00CF; read 0x54 returns 0x00CF.
5. switches=24'hA5A5A5 -> 0x44 reads 0x00A5A5A5 from the third cycle onward. Write to 0x0080 (outside window) -> no state change.
6. With MMIO_GPIO_FALL_EDGE_EN defined, release button2 -> 0x4C bit18 set; without the macro, bit18 reads 0.

Source files
------------

// File: rtl/mmio_gpio_pkg.sv
// ============================================================================
//  Module      : mmio_gpio_pkg
//  Description : Shared definitions for the memory-mapped GPIO bank. Holds
//                the byte offsets of the register window, the ID constant,
//                the word-index enum used by the address decoder and a
//                helper that builds low-order bit masks.
//  Options     : none (the MMIO_GPIO_FALL_EDGE_EN macro is consumed by the
//                modules that import this package)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mmio_gpio_pkg;

    // Byte offsets inside the 64-byte window
    localparam logic [5:0] OFF_ID   = 6'h00;
    localparam logic [5:0] OFF_SW   = 6'h04;
    localparam logic [5:0] OFF_BTN  = 6'h08;
    localparam logic [5:0] OFF_EVT  = 6'h0C;
    localparam logic [5:0] OFF_IEN  = 6'h10;
    localparam logic [5:0] OFF_LED  = 6'h14;
    localparam logic [5:0] OFF_LSET = 6'h18;
    localparam logic [5:0] OFF_LCLR = 6'h1C;

    // Reads back as ASCII "GPIO"
    localparam logic [31:0] GPIO_ID = 32'h4750_494F;

    // Bit position of the first falling-edge event / enable bit
    localparam int FALL_BASE = 16;

    // Word index (addr[5:2]) of each register
    typedef enum logic [3:0] {
        IDX_ID   = 4'(OFF_ID   >> 2),
        IDX_SW   = 4'(OFF_SW   >> 2),
        IDX_BTN  = 4'(OFF_BTN  >> 2),
        IDX_EVT  = 4'(OFF_EVT  >> 2),
        IDX_IEN  = 4'(OFF_IEN  >> 2),
        IDX_LED  = 4'(OFF_LED  >> 2),
        IDX_LSET = 4'(OFF_LSET >> 2),
        IDX_LCLR = 4'(OFF_LCLR >> 2)
    } reg_idx_e;

    // Mask with the lowest 'width' bits set (width 0..32)
    function automatic logic [31:0] low_mask(input int width);
        return 32'((64'd1 << width) - 64'd1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mmio_gpio_bank_btn_debounce.sv
// ============================================================================
//  Module      : btn_debounce
//  Description : One push-button input path: 2-flop synchroniser, stability
//                counter, accepted level and one-cycle edge pulses that are
//                coincident with the level change.
//  Options     : MMIO_GPIO_FALL_EDGE_EN adds the 'fall' pulse output.
//  Ports       : data_clk  - clock
//                rst       - asynchronous active-high reset
//                btn_raw   - raw asynchronous button
//                level     - debounced level
//                rise      - one-cycle pulse on a 0->1 level change
//                fall      - one-cycle pulse on a 1->0 level change (option)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_debounce
    import mmio_gpio_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 20000
) (
    input  logic data_clk,
    input  logic rst,
    input  logic btn_raw,
    output logic level,
    output logic rise
`ifdef MMIO_GPIO_FALL_EDGE_EN
    ,
    output logic fall
`endif
);

    localparam int             CW     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  C_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_s1;
    logic          r_s2;
    logic [CW-1:0] r_cnt;
    logic          r_level;
    logic          r_rise;
`ifdef MMIO_GPIO_FALL_EDGE_EN
    logic          r_fall;
`endif

    // The counter only runs while the synchronised input disagrees with the
    // accepted level; any return to agreement (a bounce) restarts it.
    always_ff @(posedge data_clk or posedge rst) begin
        if (rst) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
`ifdef MMIO_GPIO_FALL_EDGE_EN
            r_fall  <= 1'b0;
`endif
        end else begin
            r_s1   <= btn_raw;
            r_s2   <= r_s1;
            r_rise <= 1'b0;
`ifdef MMIO_GPIO_FALL_EDGE_EN
            r_fall <= 1'b0;
`endif
            if (r_s2 != r_level) begin
                if (r_cnt == C_LAST) begin
                    r_level <= r_s2;
                    r_cnt   <= '0;
                    r_rise  <= r_s2;
`ifdef MMIO_GPIO_FALL_EDGE_EN
                    r_fall  <= ~r_s2;
`endif
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign level = r_level;
    assign rise  = r_rise;
`ifdef MMIO_GPIO_FALL_EDGE_EN
    assign fall  = r_fall;
`endif

endmodule

`default_nettype wire

// File: rtl/mmio_gpio_bank.sv
// ============================================================================
//  Module      : mmio_gpio_bank
//  Description : Memory-mapped GPIO bank on the CPU data bus. 16-word window
//                with ID, synchronised switches, debounced buttons, sticky
//                W1C edge events, irq enables, LED register with atomic
//                set/clear and a registered 1-cycle read port.
//  Options     : MMIO_GPIO_FALL_EDGE_EN - capture falling-edge events in
//                bits [16+NUM_BTN-1:16] of EVT and IEN (NUM_BTN <= 16).
//  Ports       : data_clk, rst (async, active-high)
//                addr, write_data, wen, ren    - bus request
//                read_data, read_valid         - registered read response
//                buttons, switches             - raw asynchronous inputs
//                led                           - LED drive
//                irq                           - level interrupt request
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mmio_gpio_bank
    import mmio_gpio_pkg::*;
#(
    parameter int          NUM_BTN         = 5,
    parameter int          NUM_SW          = 24,
    parameter int          NUM_LED         = 24,
    parameter int          DEBOUNCE_CYCLES = 20000,
    parameter logic [15:0] BASE_ADDR       = 16'h0040
) (
    input  logic               data_clk,
    input  logic               rst,
    input  logic [15:0]        addr,
    input  logic [31:0]        write_data,
    input  logic               wen,
    input  logic               ren,
    output logic [31:0]        read_data,
    output logic               read_valid,
    input  logic [NUM_BTN-1:0] buttons,
    input  logic [NUM_SW-1:0]  switches,
    output logic [NUM_LED-1:0] led,
    output logic               irq
);

`ifdef MMIO_GPIO_FALL_EDGE_EN
    localparam logic [31:0] C_EVT_MASK = low_mask(NUM_BTN) | (low_mask(NUM_BTN) << FALL_BASE);
`else
    localparam logic [31:0] C_EVT_MASK = low_mask(NUM_BTN);
`endif

    logic [NUM_SW-1:0]  r_sw_s1;
    logic [NUM_SW-1:0]  r_sw_s2;
    logic [31:0]        r_evt;
    logic [31:0]        r_ien;
    logic [NUM_LED-1:0] r_led;
    logic               r_irq;
    logic [31:0]        r_rdata;
    logic               r_rvalid;

    logic [NUM_BTN-1:0] w_level;
    logic [NUM_BTN-1:0] w_rise;
`ifdef MMIO_GPIO_FALL_EDGE_EN
    logic [NUM_BTN-1:0] w_fall;
`endif
    logic               w_sel;
    reg_idx_e           w_idx;
    logic               w_wr;
    logic [31:0]        w_clr;
    logic [31:0]        w_evt_set;
    logic [31:0]        w_rd_val;
    logic [1:0]         w_unused_addr;

    assign w_sel         = (addr[15:6] == BASE_ADDR[15:6]);
    assign w_idx         = reg_idx_e'(addr[5:2]);
    assign w_wr          = wen & w_sel;
    assign w_clr         = (w_wr && (w_idx == IDX_EVT)) ? write_data : 32'd0;
    assign w_unused_addr = addr[1:0];

    // ------------------------------------------------------------------
    // Per-button debounce
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .data_clk (data_clk),
            .rst      (rst),
            .btn_raw  (buttons[gi]),
            .level    (w_level[gi]),
            .rise     (w_rise[gi])
`ifdef MMIO_GPIO_FALL_EDGE_EN
            ,
            .fall     (w_fall[gi])
`endif
        );
    end

    always_comb begin
        w_evt_set                = 32'd0;
        w_evt_set[NUM_BTN-1:0]   = w_rise;
`ifdef MMIO_GPIO_FALL_EDGE_EN
        w_evt_set[FALL_BASE +: NUM_BTN] = w_fall;
`endif
    end

    // ------------------------------------------------------------------
    // Read mux (pre-write state, so a same-cycle write is not visible)
    // ------------------------------------------------------------------
    always_comb begin
        w_rd_val = 32'd0;
        case (w_idx)
            IDX_ID:  w_rd_val = GPIO_ID;
            IDX_SW:  w_rd_val = 32'(r_sw_s2);
            IDX_BTN: w_rd_val = 32'(w_level);
            IDX_EVT: w_rd_val = r_evt;
            IDX_IEN: w_rd_val = r_ien;
            IDX_LED: w_rd_val = 32'(r_led);
            default: w_rd_val = 32'd0;
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge data_clk or posedge rst) begin
        if (rst) begin
            r_sw_s1  <= '0;
            r_sw_s2  <= '0;
            r_evt    <= 32'd0;
            r_ien    <= 32'd0;
            r_led    <= '0;
            r_irq    <= 1'b0;
            r_rdata  <= 32'd0;
            r_rvalid <= 1'b0;
        end else begin
            r_sw_s1 <= switches;
            r_sw_s2 <= r_sw_s1;

            // New edges take priority over a simultaneous W1C
            r_evt <= (w_evt_set | (r_evt & ~w_clr)) & C_EVT_MASK;
            r_irq <= |(r_evt & r_ien);

            if (w_wr) begin
                case (w_idx)
                    IDX_IEN:  r_ien <= write_data & C_EVT_MASK;
                    IDX_LED:  r_led <= write_data[NUM_LED-1:0];
                    IDX_LSET: r_led <= r_led | write_data[NUM_LED-1:0];
                    IDX_LCLR: r_led <= r_led & ~write_data[NUM_LED-1:0];
                    default:  ;
                endcase
            end

            if (ren && w_sel) begin
                r_rdata  <= w_rd_val;
                r_rvalid <= 1'b1;
            end else begin
                r_rvalid <= 1'b0;
            end
        end
    end

    assign read_data  = r_rdata;
    assign read_valid = r_rvalid;
    assign led        = r_led;
    assign irq        = r_irq;

endmodule

`default_nettype wire

// File: tb/tb_mmio_gpio_bank.sv
// ============================================================================
//  Module      : tb_mmio_gpio_bank
//  Description : Self-checking bench for mmio_gpio_bank with directed steps
//                followed by randomised bus and input traffic, compared
//                against a cycle-level behavioural model.
//  Options     : honours MMIO_GPIO_FALL_EDGE_EN
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mmio_gpio_bank;

    localparam int          NB     = 5;
    localparam int          NS     = 24;
    localparam int          NL     = 24;
    localparam int          DB     = 4;
    localparam logic [31:0] ID_VAL = 32'h4750_494F;

    logic           data_clk = 1'b0;
    logic           rst;
    logic [15:0]    addr;
    logic [31:0]    write_data;
    logic           wen;
    logic           ren;
    logic [31:0]    read_data;
    logic           read_valid;
    logic [NB-1:0]  buttons;
    logic [NS-1:0]  switches;
    logic [NL-1:0]  led;
    logic           irq;

    mmio_gpio_bank #(
        .NUM_BTN         (NB),
        .NUM_SW          (NS),
        .NUM_LED         (NL),
        .DEBOUNCE_CYCLES (DB),
        .BASE_ADDR       (16'h0040)
    ) dut (
        .data_clk   (data_clk),
        .rst        (rst),
        .addr       (addr),
        .write_data (write_data),
        .wen        (wen),
        .ren        (ren),
        .read_data  (read_data),
        .read_valid (read_valid),
        .buttons    (buttons),
        .switches   (switches),
        .led        (led),
        .irq        (irq)
    );

    always #5 data_clk = ~data_clk;

    // ---------------- reference model state ----------------
    logic [NS-1:0] sw_hist[$];   // last two switch samples; [0] is visible
    logic [NB-1:0] btn_hist[$];  // last two button samples; [0] is "sync"
    int            m_streak[NB]; // cycles the sync value has disagreed
    logic [NB-1:0] m_level, m_rise, m_fall;
    logic [31:0]   m_evt, m_ien, m_rd;
    logic [NL-1:0] m_led;
    logic          m_irq, m_rv;
    logic [31:0]   evt_mask;

    int n_vec = 0;
    int n_err = 0;

    function automatic logic [31:0] lmask(input int w);
        return 32'((64'd1 << w) - 64'd1);
    endfunction

    function automatic logic [31:0] m_read(input logic [3:0] idx);
        case (idx)
            4'd0:    return ID_VAL;
            4'd1:    return 32'(sw_hist[0]);
            4'd2:    return 32'(m_level);
            4'd3:    return m_evt;
            4'd4:    return m_ien;
            4'd5:    return 32'(m_led);
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        sw_hist.delete();  sw_hist.push_back('0);  sw_hist.push_back('0);
        btn_hist.delete(); btn_hist.push_back('0); btn_hist.push_back('0);
        for (int i = 0; i < NB; i++) m_streak[i] = 0;
        m_level = '0; m_rise = '0; m_fall = '0;
        m_evt = '0; m_ien = '0; m_rd = '0; m_led = '0; m_irq = 1'b0; m_rv = 1'b0;
    endtask

    // One clock edge of the model, using pre-edge state and current inputs
    task automatic model_step();
        logic          sel, wr;
        logic [3:0]    idx;
        logic [31:0]   clr, setv;
        logic [NB-1:0] sync;
        sel = (addr[15:6] == 10'h001);
        idx = addr[5:2];
        wr  = wen && sel;
        if (ren && sel) begin
            m_rd = m_read(idx);
            m_rv = 1'b1;
        end else begin
            m_rv = 1'b0;
        end
        m_irq = |(m_evt & m_ien);
        clr   = (wr && idx == 4'd3) ? write_data : 32'd0;
        setv  = 32'(m_rise);
`ifdef MMIO_GPIO_FALL_EDGE_EN
        setv  = setv | (32'(m_fall) << 16);
`endif
        m_evt = (setv | (m_evt & ~clr)) & evt_mask;
        if (wr && idx == 4'd4) m_ien = write_data & evt_mask;
        if (wr && idx == 4'd5) m_led = write_data[NL-1:0];
        if (wr && idx == 4'd6) m_led = m_led | write_data[NL-1:0];
        if (wr && idx == 4'd7) m_led = m_led & ~write_data[NL-1:0];
        // A level is accepted after DB consecutive disagreeing cycles
        sync   = btn_hist[0];
        m_rise = '0;
        m_fall = '0;
        for (int i = 0; i < NB; i++) begin
            if (sync[i] != m_level[i]) begin
                m_streak[i]++;
                if (m_streak[i] == DB) begin
                    m_level[i]  = sync[i];
                    m_streak[i] = 0;
                    m_rise[i]   = sync[i];
                    m_fall[i]   = !sync[i];
                end
            end else begin
                m_streak[i] = 0;
            end
        end
        sw_hist.push_back(switches);  void'(sw_hist.pop_front());
        btn_hist.push_back(buttons);  void'(btn_hist.pop_front());
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge data_clk);
        model_step();
        #1;
        chk32("led", 32'(led), 32'(m_led));
        chk32("irq", 32'(irq), 32'(m_irq));
        chk32("read_valid", 32'(read_valid), 32'(m_rv));
        chk32("read_data", read_data, m_rd);
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
        addr = a; write_data = d; wen = 1'b1; ren = 1'b0;
        tick();
        wen = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] a);
        addr = a; ren = 1'b1; wen = 1'b0;
        tick();
        ren = 1'b0;
    endtask

    initial begin
        logic [NL-1:0] led_before;
        logic          fall_exp;
        int            k;
        evt_mask = lmask(NB);
        fall_exp = 1'b0;
`ifdef MMIO_GPIO_FALL_EDGE_EN
        evt_mask = evt_mask | (lmask(NB) << 16);
        fall_exp = 1'b1;
`endif
        rst = 1'b1; addr = '0; write_data = '0; wen = 1'b0; ren = 1'b0;
        buttons = '0; switches = '0;
        repeat (3) @(posedge data_clk);
        #1;
        model_reset();
        chk32("rst_read_data", read_data, 32'd0);
        chk32("rst_read_valid", 32'(read_valid), 32'd0);
        chk32("rst_led", 32'(led), 32'd0);
        chk32("rst_irq", 32'(irq), 32'd0);
        @(negedge data_clk);
        rst = 1'b0;

        // 1. ID read, single-cycle valid, write-only register reads 0
        bus_read(16'h0040);
        chk32("id_value", read_data, ID_VAL);
        chk32("id_valid", 32'(read_valid), 32'd1);
        tick();
        chk32("valid_drops", 32'(read_valid), 32'd0);
        bus_read(16'h005C);
        chk32("lclr_reads_zero", read_data, 32'd0);

        // 2. Button0 with a one-cycle glitch; level appears on the 7th read
        buttons[0] = 1'b1; tick(); tick();
        buttons[0] = 1'b0; tick();
        buttons[0] = 1'b1;
        for (int r = 0; r < 8; r++) begin
            bus_read(16'h0048);
            chk32("debounce_level", read_data & 32'd1, (r >= 6) ? 32'd1 : 32'd0);
        end

        // 3. irq enable, clear latency, set-wins over W1C
        bus_write(16'h0050, 32'd1);
        tick(); tick();
        chk32("irq_on", 32'(irq), 32'd1);
        bus_write(16'h004C, 32'hFFFF_FFFF);
        chk32("irq_still_on", 32'(irq), 32'd1);
        tick();
        chk32("irq_off", 32'(irq), 32'd0);
        buttons[0] = 1'b0;
        repeat (10) tick();
        bus_write(16'h004C, 32'hFFFF_FFFF);
        buttons[0] = 1'b1;
        k = 0;
        while (!m_rise[0] && k < 40) begin tick(); k++; end
        chk32("rise_seen", 32'(m_rise[0]), 32'd1);
        bus_write(16'h004C, 32'd1);
        bus_read(16'h004C);
        chk32("evt_set_wins", read_data & 32'd1, 32'd1);
        bus_write(16'h004C, 32'hFFFF_FFFF);
        bus_write(16'h0050, 32'd0);

        // 4. LED write / set / clear
        bus_write(16'h0054, 32'h0000_00F0);
        bus_write(16'h0058, 32'h0000_000F);
        bus_write(16'h005C, 32'h0000_0030);
        chk32("led_value", 32'(led), 32'h0000_00CF);
        bus_read(16'h0054);
        chk32("led_read", read_data, 32'h0000_00CF);

        // 5. Switch latency and out-of-window writes
        switches = 24'hA5A5A5;
        bus_read(16'h0044); chk32("sw_read0", read_data, 32'd0);
        bus_read(16'h0044); chk32("sw_read1", read_data, 32'd0);
        bus_read(16'h0044); chk32("sw_read2", read_data, 32'h00A5_A5A5);
        led_before = led;
        bus_write(16'h0080, 32'h1234_5678);
        bus_write(16'h0094, 32'h0000_0000);
        chk32("outside_write", 32'(led), 32'(led_before));

        // 6. Falling edge on button2
        bus_write(16'h004C, 32'hFFFF_FFFF);
        buttons[2] = 1'b1; repeat (10) tick();
        buttons[2] = 1'b0; repeat (10) tick();
        bus_read(16'h004C);
        chk32("fall_bit18", (read_data >> 18) & 32'd1, 32'(fall_exp));

        // Randomised traffic
        for (int n = 0; n < 400; n++) begin
            int op;
            if ($urandom_range(0, 9) == 0) buttons[$urandom_range(0, NB-1)] ^= 1'b1;
            if ($urandom_range(0, 19) == 0) switches = NS'($urandom);
            if ($urandom_range(0, 9) == 0)
                addr = 16'h0080 | 16'($urandom_range(0, 63));
            else
                addr = 16'h0040 | 16'($urandom_range(0, 63));
            write_data = $urandom;
            op  = $urandom_range(0, 3);
            ren = (op == 1 || op == 3);
            wen = (op == 2 || op == 3);
            tick();
        end
        wen = 1'b0; ren = 1'b0;

        // Asynchronous reset between edges
        bus_write(16'h0054, 32'h00FF_FFFF);
        bus_read(16'h0054);
        @(negedge data_clk);
        rst = 1'b1;
        #1;
        chk32("async_rst_led", 32'(led), 32'd0);
        chk32("async_rst_valid", 32'(read_valid), 32'd0);
        chk32("async_rst_data", read_data, 32'd0);
        chk32("async_rst_irq", 32'(irq), 32'd0);
        model_reset();
        @(negedge data_clk);
        rst = 1'b0;
        repeat (3) tick();
        bus_read(16'h004C);
        bus_read(16'h0048);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
